// File: rtl/cache_ctrl.sv
// cache_ctrl: read-path controller for a 4-line x 8-byte direct-mapped cache.
//
// Accepts byte reads from the CPU and checks a 4-entry {valid, tag} store.
// Hits are answered from the cache RAM. On a miss the controller fills the
// whole line from memory, offsets 0..7 in order, then answers from the cache.
// The cache RAM is clocked on the falling edge. Fill writes and the response
// read therefore land on falling edges that do not overlap.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cpu_req/cpu_addr      byte read request, taken when cpu_ready=1
//   cpu_ready             request can be taken (IDLE and no flush)
//   cpu_valid/cpu_rdata   one-cycle response pulse and registered data byte
//   flush                 invalidate every line (honoured in IDLE only)
//   mem_req/mem_addr      memory byte read during a line fill
//   mem_ack/mem_data      memory data strobe and data
//   cache_wren/wrline/wroffset/data   cache RAM byte write port
//   cache_rdline/rdoffset/cache_q     cache RAM read port
//   hit_count/miss_count  saturating event counters (CACHE_CTRL_STATS_EN only)
//
// Build option: define CACHE_CTRL_STATS_EN to add the hit/miss counters of
// width STAT_W.
module cache_ctrl #(
  parameter int unsigned STAT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic [7:0] cpu_addr,
  output logic       cpu_ready,
  output logic       cpu_valid,
  output logic [7:0] cpu_rdata,
`ifdef CACHE_CTRL_STATS_EN
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] miss_count,
`endif
  input  logic       flush,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       cache_wren,
  output logic [1:0] cache_wrline,
  output logic [2:0] cache_wroffset,
  output logic [7:0] cache_data,
  output logic [1:0] cache_rdline,
  output logic [2:0] cache_rdoffset,
  input  logic [7:0] cache_q
);

  typedef enum logic [1:0] {StIdle, StLookup, StFill, StResp} state_e;

  state_e          state_q;
  logic [3:0]      valid_q;
  logic [3:0][2:0] tag_q;
  logic [7:0]      req_addr_q;
  logic [2:0]      fill_cnt_q;

  logic [2:0] req_tag;
  logic [1:0] req_line;
  logic       hit;

  assign req_tag  = req_addr_q[7:5];
  assign req_line = req_addr_q[4:3];
  assign hit      = valid_q[req_line] && (tag_q[req_line] == req_tag);

  // flush takes priority over a same-cycle request, so ready drops with it.
  assign cpu_ready = (state_q == StIdle) && !flush;

  assign mem_req  = (state_q == StFill);
  assign mem_addr = {req_tag, req_line, fill_cnt_q};

  // The write must happen in the ack cycle itself because mem_data is only
  // guaranteed while mem_ack is high. The RAM captures it on the falling edge.
  assign cache_wren     = (state_q == StFill) && mem_ack;
  assign cache_wrline   = req_line;
  assign cache_wroffset = fill_cnt_q;
  assign cache_data     = mem_data;

  assign cache_rdline   = req_line;
  assign cache_rdoffset = req_addr_q[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      tag_q      <= '0;
      req_addr_q <= '0;
      fill_cnt_q <= '0;
      cpu_valid  <= 1'b0;
      cpu_rdata  <= '0;
`ifdef CACHE_CTRL_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      cpu_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            valid_q <= '0;
          end else if (cpu_req) begin
            req_addr_q <= cpu_addr;
            state_q    <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            state_q <= StResp;
`ifdef CACHE_CTRL_STATS_EN
            if (hit_count != {STAT_W{1'b1}}) hit_count <= hit_count + 1'b1;
`endif
          end else begin
            // Invalidate the victim now so an aborted fill leaves no stale hit.
            valid_q[req_line] <= 1'b0;
            fill_cnt_q        <= '0;
            state_q           <= StFill;
`ifdef CACHE_CTRL_STATS_EN
            if (miss_count != {STAT_W{1'b1}}) miss_count <= miss_count + 1'b1;
`endif
          end
        end
        StFill: begin
          if (mem_ack) begin
            fill_cnt_q <= fill_cnt_q + 3'd1;
            if (fill_cnt_q == 3'd7) begin
              valid_q[req_line] <= 1'b1;
              tag_q[req_line]   <= req_tag;
              state_q           <= StResp;
            end
          end
        end
        StResp: begin
          // cache_q was read on the falling edge inside this cycle.
          cpu_rdata <= cache_q;
          cpu_valid <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Testbench for cache_ctrl: a falling-edge cache RAM model, a memory model
// with a configurable ack rate (data = addr ^ 0xA5), and a response scoreboard.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic [7:0] cpu_addr;
  logic       cpu_ready;
  logic       cpu_valid;
  logic [7:0] cpu_rdata;
  logic       flush;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       cache_wren;
  logic [1:0] cache_wrline;
  logic [2:0] cache_wroffset;
  logic [7:0] cache_data;
  logic [1:0] cache_rdline;
  logic [2:0] cache_rdoffset;
  logic [7:0] cache_q;
`ifdef CACHE_CTRL_STATS_EN
  logic [1:0] hit_count;
  logic [1:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;
  int ack_period = 1;
  logic [7:0] exp_q[$];
  logic [7:0] ram [32];

  always #5 clk = ~clk;

  cache_ctrl #(.STAT_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_ready     (cpu_ready),
    .cpu_valid     (cpu_valid),
    .cpu_rdata     (cpu_rdata),
`ifdef CACHE_CTRL_STATS_EN
    .hit_count     (hit_count),
    .miss_count    (miss_count),
`endif
    .flush         (flush),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .cache_wren    (cache_wren),
    .cache_wrline  (cache_wrline),
    .cache_wroffset(cache_wroffset),
    .cache_data    (cache_data),
    .cache_rdline  (cache_rdline),
    .cache_rdoffset(cache_rdoffset),
    .cache_q       (cache_q)
  );

  // Cache RAM: byte write and offset-selected read on the falling edge.
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 8'h00;
    cache_q = 8'h00;
    forever begin
      @(negedge clk);
      if (cache_wren) ram[{cache_wrline, cache_wroffset}] = cache_data;
      cache_q = ram[{cache_rdline, cache_rdoffset}];
    end
  end

  // Memory: ack on every ack_period-th FILL cycle, data = address ^ 0xA5.
  initial begin
    int w;
    w = 0;
    mem_ack = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        w++;
        if (w >= ack_period) begin
          mem_ack = 1'b1;
          w = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        mem_ack = 1'b0;
        w = 0;
      end
      mem_data = mem_addr ^ 8'hA5;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one read at posedge+1 and wait for the response. exp_beats is 8 for
  // a miss and 0 for a hit. The task returns at posedge+1.
  task automatic do_read(input logic [7:0] addr, input int exp_beats);
    int lat, fills, beats;
    bit got;
    logic [2:0] b;
    logic [7:0] exp_byte;
    check("ready_before_req", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b1;
    cpu_addr = addr;
    exp_q.push_back(addr ^ 8'hA5);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    lat = 0;
    fills = 0;
    beats = 0;
    got = 1'b0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (mem_req) fills++;
      if (cache_wren) begin
        b = beats[2:0];
        check("fill_mem_addr", 32'(mem_addr), 32'({addr[7:3], b}));
        check("fill_wroffset", 32'(cache_wroffset), 32'(b));
        check("fill_wrline", 32'(cache_wrline), 32'(addr[4:3]));
        check("fill_wrdata", 32'(cache_data), 32'({addr[7:3], b} ^ 8'hA5));
        beats++;
      end
      if (cpu_valid) got = 1'b1;
    end
    check("response_seen", 32'(got), 32'd1);
    if (got) begin
      exp_byte = exp_q.pop_front();
      check("cpu_rdata", 32'(cpu_rdata), 32'(exp_byte));
      check("fill_beats", 32'(beats), 32'(exp_beats));
      check("fill_cycles", 32'(fills), 32'(exp_beats * ack_period));
      check("latency", 32'(lat), 32'(3 + fills));
      @(negedge clk);
      check("valid_one_cycle", 32'(cpu_valid), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, vseen;
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_addr = 8'h00;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cache_wren", 32'(cache_wren), 32'd0);
    check("rst_rd_addr", 32'({cache_rdline, cache_rdoffset}), 32'd0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Cold miss, then a hit on the same byte.
    ack_period = 1;
    do_read(8'h2B, 8);
    do_read(8'h2B, 0);
    // Conflict on line 1 with tag 3, then the old tag misses again.
    do_read(8'h68, 8);
    do_read(8'h2B, 8);
    // Slow memory with an ack every third FILL cycle.
    ack_period = 3;
    do_read(8'h50, 8);
    ack_period = 1;

    // A flush and a request in the same cycle: the flush wins.
    flush = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 8'h2B;
    #1;
    check("flush_blocks_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("flush_no_accept_memreq", 32'(mem_req), 32'd0);
    check("flush_no_accept_ready", 32'(cpu_ready), 32'd1);
    @(posedge clk);
    #1;
    do_read(8'h2B, 8);
    do_read(8'h50, 8);

    // Reset after four fill acks.
    cpu_req = 1'b1;
    cpu_addr = 8'h68;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 4; i++) begin
      @(negedge clk);
      if (cache_wren) n++;
    end
    check("midfill_acks_seen", 32'(n), 32'd4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midfill_rst_memreq", 32'(mem_req), 32'd0);
    check("midfill_rst_idle", 32'(cpu_ready), 32'd1);
    vseen = 0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_valid) vseen++;
      @(negedge clk);
    end
    check("midfill_no_valid", 32'(vseen), 32'd0);
    @(posedge clk);
    #1;
    do_read(8'h68, 8);

    // Five hits after one miss. With STAT_W=2 the hit counter saturates at 3.
    for (int i = 0; i < 5; i++) do_read(8'h68 + 8'(i), 0);
`ifdef CACHE_CTRL_STATS_EN
    check("hit_count_sat", 32'(hit_count), 32'd3);
    check("miss_count", 32'(miss_count), 32'd1);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
